// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - register map, display codes and BCD helpers shared by the display register block.
package display_pkg;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_BUF0   = 3'd1;
    localparam logic [2:0] OFF_BUF1   = 3'd2;
    localparam logic [2:0] OFF_BUF2   = 3'd3;
    localparam logic [2:0] OFF_BUF3   = 3'd4;
    localparam logic [2:0] OFF_BIN_LO = 3'd5;
    localparam logic [2:0] OFF_BIN_HI = 3'd6;
    localparam logic [2:0] OFF_STATUS = 3'd7;

    localparam logic [7:0] BLANK = 8'h10;
    localparam logic [7:0] DASH  = 8'h11;

    localparam int BCD_ITER = 14;
    localparam int MAX_DEC  = 9999;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LOAD
    } bcd_state_t;

    // Double-dabble correction: any digit >= 5 gets +3 so the next shift carries correctly.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] acc);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
        end
        return r;
    endfunction

    function automatic logic [7:0] digit_code(input logic blank, input logic [3:0] digit);
        return blank ? BLANK : {4'h0, digit};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 14-bit binary to 4-digit BCD converter, one double-dabble step per clock.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [13:0] value,
    output logic        busy,
    output logic        done,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3
);

    bcd_state_t  state;
    logic [13:0] shreg;
    logic [15:0] acc;
    logic [15:0] adj;
    logic [3:0]  cnt;

    assign adj = bcd_adjust(acc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg <= value;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc   <= {adj[14:0], shreg[13]};
                    shreg <= {shreg[12:0], 1'b0};
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'(BCD_ITER - 1)) begin
                        done  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign digit0 = acc[15:12];
    assign digit1 = acc[11:8];
    assign digit2 = acc[7:4];
    assign digit3 = acc[3:0];

endmodule

// File: rtl/display_regs_b3.sv
// rtl/display_regs_b3.sv - I/O-bus register file for the Basys3 7-segment display with binary-to-BCD loading.
module display_regs_b3
    import display_pkg::*;
#(
    parameter logic [5:0] BASE_ADDR = 6'h20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] io_addr,
    input  logic [7:0] io_dout,
    input  logic       io_we,
    output logic [7:0] io_din,
    output logic       display_ctrl,
    output logic [7:0] display_buf0,
    output logic [7:0] display_buf1,
    output logic [7:0] display_buf2,
    output logic [7:0] display_buf3
);

    logic [1:0]  ctrl;
    logic [7:0]  bin_lo;
    logic [5:0]  bin_hi;
    logic        overflow;
    logic [7:0]  bufs   [4];
    logic [7:0]  commit [4];
    logic [3:0]  dig    [4];
    logic [6:0]  rel;
    logic        hit;
    logic [2:0]  off;
    logic        wr_en;
    logic        start;
    logic        busy;
    logic        done;
    logic [13:0] bin_value;
    logic        lead0, lead1, lead2;

    assign rel   = {1'b0, io_addr} - {1'b0, BASE_ADDR};
    assign hit   = ({1'b0, io_addr} >= {1'b0, BASE_ADDR}) && (rel < 7'd8);
    assign off   = rel[2:0];
    assign wr_en = io_we && hit;
    // A BIN_HI write while busy still updates the register but must not restart.
    assign start = wr_en && (off == OFF_BIN_HI) && !busy;
    assign bin_value = {io_dout[5:0], bin_lo};

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .value   (bin_value),
        .busy    (busy),
        .done    (done),
        .digit0  (dig[0]),
        .digit1  (dig[1]),
        .digit2  (dig[2]),
        .digit3  (dig[3])
    );

    always_comb begin
        lead0 = ctrl[1] && (dig[0] == 4'd0);
        lead1 = lead0 && (dig[1] == 4'd0);
        lead2 = lead1 && (dig[2] == 4'd0);
        commit[0] = overflow ? DASH : digit_code(lead0, dig[0]);
        commit[1] = overflow ? DASH : digit_code(lead1, dig[1]);
        commit[2] = overflow ? DASH : digit_code(lead2, dig[2]);
        commit[3] = overflow ? DASH : digit_code(1'b0, dig[3]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl     <= '0;
            bin_lo   <= '0;
            bin_hi   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < 4; i++) bufs[i] <= BLANK;
        end else begin
            if (wr_en) begin
                case (off)
                    OFF_CTRL:   ctrl    <= io_dout[1:0];
                    OFF_BUF0:   bufs[0] <= io_dout;
                    OFF_BUF1:   bufs[1] <= io_dout;
                    OFF_BUF2:   bufs[2] <= io_dout;
                    OFF_BUF3:   bufs[3] <= io_dout;
                    OFF_BIN_LO: bin_lo  <= io_dout;
                    OFF_BIN_HI: bin_hi  <= io_dout[5:0];
                    default: ;
                endcase
            end
            if (start) overflow <= (bin_value > 14'(MAX_DEC));
            // Placed after the CPU writes so the conversion result wins a same-cycle collision.
            if (done) begin
                for (int i = 0; i < 4; i++) bufs[i] <= commit[i];
            end
        end
    end

    always_comb begin
        io_din = 8'h00;
        if (hit) begin
            case (off)
                OFF_CTRL:   io_din = {6'b0, ctrl};
                OFF_BUF0:   io_din = bufs[0];
                OFF_BUF1:   io_din = bufs[1];
                OFF_BUF2:   io_din = bufs[2];
                OFF_BUF3:   io_din = bufs[3];
                OFF_BIN_LO: io_din = bin_lo;
                OFF_BIN_HI: io_din = {2'b0, bin_hi};
                OFF_STATUS: io_din = {6'b0, overflow, busy};
                default:    io_din = 8'h00;
            endcase
        end
    end

    assign display_ctrl = ctrl[0];
    assign display_buf0 = bufs[0];
    assign display_buf1 = bufs[1];
    assign display_buf2 = bufs[2];
    assign display_buf3 = bufs[3];

endmodule
